// File: rtl/pipe_field.sv
// pipe_field: scrolling obstacle generator for the Flappy Bird playfield.
// Holds NUM_PIPES pipes at fixed spacing. On every frame update they move
// left by the effective speed. A pipe that would pass the left edge wraps to
// the right and takes a new pseudo-random gap height from a free-running
// 16-bit LFSR. The block also counts pipes that cross the bird column.
// Optional feature macro: PIPE_SPEEDUP_EN (adds score[9:4] to the speed,
// saturating at the largest value the speed input can hold).
module pipe_field #(
  parameter int          NUM_PIPES = 3,
  parameter int          SCREEN_W  = 640,
  parameter int          SPACING   = 220,
  parameter int          START_X   = 320,
  parameter int          GAP_MIN   = 120,
  parameter int          GAP_MAX   = 360,
  parameter int          BIRD_X    = 160,
  parameter int          SPEED_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     freeze,
  input  logic [SPEED_W-1:0]       speed,
  output logic [NUM_PIPES*10-1:0]  pipe_x,
  output logic [NUM_PIPES*10-1:0]  gap_y,
  output logic [NUM_PIPES-1:0]     pipe_visible,
  output logic                     score_pulse,
  output logic [9:0]               score
);

  // Distance a pipe travels before it reappears in the same slot.
  localparam logic [9:0]  WRAP_DIST  = 10'(NUM_PIPES * SPACING);
  localparam logic [9:0]  GAP_MID    = 10'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [15:0] GAP_RANGE  = 16'(GAP_MAX - GAP_MIN + 1);
  localparam logic [9:0]  BIRD_COL   = 10'(BIRD_X);
  localparam logic [9:0]  SCREEN_LIM = 10'(SCREEN_W);
  localparam logic [9:0]  SCORE_MAX  = 10'd999;

  logic [15:0]          lfsr_reg;
  logic [15:0]          lfsr_next;
  logic [9:0]           score_reg;
  logic                 hit_reg;
  logic                 score_pulse_reg;
  logic [9:0]           step;
  logic                 update;
  logic [9:0]           x_reg    [NUM_PIPES];
  logic [9:0]           gap_reg  [NUM_PIPES];
  logic [NUM_PIPES-1:0] pipe_hit;

  // A tick is honoured only while the playfield is live; missed ticks are lost.
  assign update = frame_tick & ~freeze;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  // Free-running LFSR: keeps stepping while frozen so gaps depend on player timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

`ifdef PIPE_SPEEDUP_EN
  localparam logic [10:0] STEP_CAP = 11'((1 << SPEED_W) - 1);
  logic [10:0] step_sum;
  assign step_sum = 11'(speed) + 11'(score_reg[9:4]);

  // Effective speed grows by one every 16 points, clamped to the speed range.
  always_comb begin
    step = 10'(speed);
    if (step_sum > STEP_CAP) begin
      step = STEP_CAP[9:0];
    end else begin
      step = step_sum[9:0];
    end
  end
`else
  assign step = 10'(speed);
`endif

  generate
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      localparam int          ROT     = (3 * gi) % 16;
      localparam logic [9:0]  X_RESET = 10'(START_X + gi * SPACING);

      logic        respawn;
      logic [9:0]  x_next;
      logic [15:0] rot_val;
      logic [9:0]  gap_next;

      // Each pipe reads the LFSR through its own rotation so simultaneous
      // respawns do not share a gap height.
      assign rot_val  = 16'({lfsr_reg, lfsr_reg} >> (16 - ROT));
      assign gap_next = 10'(16'(GAP_MIN) + (rot_val % GAP_RANGE));

      // Wrapping adds the full ring length so inter-pipe spacing stays exact.
      assign respawn  = (x_reg[gi] < step);
      assign x_next   = respawn ? (x_reg[gi] + WRAP_DIST - step) : (x_reg[gi] - step);
      assign pipe_hit[gi] = update && !respawn && (x_reg[gi] >= BIRD_COL) && (x_next < BIRD_COL);

      // Position and gap move only on a live frame update.
      always_ff @(posedge clk) begin
        if (reset) begin
          x_reg[gi]   <= X_RESET;
          gap_reg[gi] <= GAP_MID;
        end else if (update) begin
          x_reg[gi] <= x_next;
          if (respawn) begin
            gap_reg[gi] <= gap_next;
          end
        end
      end

      assign pipe_x[gi*10 +: 10]  = x_reg[gi];
      assign gap_y[gi*10 +: 10]   = gap_reg[gi];
      assign pipe_visible[gi]     = (x_reg[gi] < SCREEN_LIM);
    end
  endgenerate

  // Score path: the hit is captured on the update edge and turned into a pulse
  // plus a single increment on the following edge, independent of freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_reg         <= 1'b0;
      score_pulse_reg <= 1'b0;
      score_reg       <= 10'd0;
    end else begin
      hit_reg         <= |pipe_hit;
      score_pulse_reg <= hit_reg;
      if (hit_reg && (score_reg != SCORE_MAX)) begin
        score_reg <= score_reg + 10'd1;
      end
    end
  end

  assign score_pulse = score_pulse_reg;
  assign score       = score_reg;

endmodule

// File: doc/pipe_field.md
Name: pipe_field

Overview:
- Parametrised obstacle generator for the Flappy Bird game. It holds NUM_PIPES pipes at fixed horizontal spacing and scrolls them left once per video frame by a runtime speed.
- Pipes leaving the left edge respawn on the right with a pseudo-random gap height from an internal LFSR.
- It detects pipes passing the bird column and keeps a score.
- Sits between the frame-tick generator and the renderer/collision logic.

Parameters:
- NUM_PIPES, 3, number of simultaneous pipes (1..4)
- SCREEN_W, 640, visible width in pixels
- SPACING, 220, horizontal distance between consecutive pipes; NUM_PIPES*SPACING must be ≥ SCREEN_W and ≤ 1023
- START_X, 320, reset x of pipe 0; START_X+(NUM_PIPES-1)*SPACING must be ≤ 1023
- GAP_MIN, 120, smallest gap centre y
- GAP_MAX, 360, largest gap centre y
- BIRD_X, 160, bird column used for scoring
- SPEED_W, 4, width of speed input
- LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-high
- frame_tick, in, 1, one-cycle pulse per frame
- freeze, in, 1, holds the playfield (game over / pause)
- speed, in, SPEED_W, pixels moved per frame
- pipe_x, out, NUM_PIPES*10, packed x positions; pipe i at bits [10i+9:10i]
- gap_y, out, NUM_PIPES*10, packed gap centres; same packing
- pipe_visible, out, NUM_PIPES, bit i = (x_i < SCREEN_W)
- score_pulse, out, 1, one-cycle pulse per pipe passed
- score, out, 10, passed-pipe count, saturates at 999

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - x_i = START_X + i*SPACING; gap_i = (GAP_MIN+GAP_MAX)/2; score = 0; score_pulse = 0; LFSR = LFSR_SEED.
  - Reset has priority over every other input. A reset mid-game restores these values on the next edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, including while frozen or with no tick, so gap values depend on player timing.
- Random gap for pipe i: GAP_MIN + (R_i mod (GAP_MAX-GAP_MIN+1)), where R_i = LFSR rotated left by 3*i.
- Update occurs on a clock with frame_tick=1 and freeze=0 only; otherwise all state except the LFSR holds. speed is sampled on the update cycle.
- Per pipe, with s = effective speed:
  - If x_i ≥ s: x_i ← x_i - s; gap_i unchanged.
  - If x_i < s (respawn): x_i ← x_i + NUM_PIPES*SPACING - s; gap_i ← random gap computed from the current-cycle LFSR.
  - This keeps spacing exact, and all arithmetic is 10-bit with no underflow.
- s = 0: no movement, no respawn, no scoring.
- Scoring:
  - A pipe scores when it moves without respawn and old x_i ≥ BIRD_X and new x_i < BIRD_X.
  - If any pipe scores in an update, score_pulse = 1 on the clock after the update (registered, 1-cycle latency) and score increments by exactly 1, even if several pipes score in the same update.
  - score holds at 999.
- pipe_visible is combinational from the registered x.
- freeze asserted together with frame_tick: the tick is ignored. Deasserting freeze does not replay missed ticks.
- A score_pulse already in flight when freeze asserts still fires.

Optional Feature:
- Macro PIPE_SPEEDUP_EN.
- Defined: effective speed s = min(speed + score[9:4], 2^SPEED_W - 1), so the game accelerates every 16 points.
- Undefined: s = speed. score still counts; no other change.

Test Plan:
1. Reset with defaults → x = {320, 540, 760}, gap = {240, 240, 240}, score = 0, pipe_visible = 3'b011.
2. speed = 4, one frame_tick → x = {316, 536, 756}. Repeat for 39 more ticks → x_0 = 160, score = 0. The next tick gives x_0 = 156, a score_pulse exactly one clock later, and score = 1.
3. Force x_0 = 2, speed = 4, tick → x_0 = 658 and gap_0 in [120, 360], equal to the model value from the LFSR of that cycle.
4. freeze = 1 with 10 frame_ticks → x, gap and score unchanged. The LFSR still advances (check that a later respawn gap differs from the no-freeze run).
5. score preset to 999 while passing a pipe → score_pulse = 1, score stays 999. Assert reset mid-run → all outputs return to the reset values on the next edge.
6. PIPE_SPEEDUP_EN defined, speed = 4, score = 32 → per-tick step of 6. With speed = 14 and score = 48 → step capped at 15.
